seq_scan_ctrl: RTL

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
//
// Serial pattern scanner. A scan is launched from IDLE by start, using a
// pattern length of 1..8 bits, overlapping or non-overlapping detection, and a
// target match count. The configuration is latched at launch. Qualified
// serial bits are shifted into a history register. Each detected pattern gives
// a one-cycle match pulse. When the target count is reached, the scan ends
// with a one-cycle done pulse.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   start        : launch a scan (honoured only in IDLE)
//   abort        : terminate an active scan (honoured only in SCAN)
//   cfg_pattern  : target pattern, first-received bit is cfg_pattern[cfg_len-1]
//   cfg_len      : pattern length, legal 1..8
//   cfg_overlap  : 1 = overlapping detection, 0 = non-overlapping
//   cfg_target   : match count that ends a scan, legal 1..255
//   in, in_valid : serial data bit and its qualifier
//   match        : one-cycle pulse per detected pattern
//   match_count  : matches counted in the current or last scan
//   busy         : high while scanning
//   done         : one-cycle pulse when the target count is reached
//   err          : one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module seq_scan_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] cfg_pattern,
   input  logic [3:0] cfg_len,
   input  logic       cfg_overlap,
   input  logic [7:0] cfg_target,
   input  logic       in,
   input  logic       in_valid,
   output logic       match,
   output logic [7:0] match_count,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_next;

   // Only the newest 7 bits of history are needed. The incoming bit
   // completes the 8-bit compare window.
   logic [6:0] r_hist;
   logic [6:0] w_hist_next;
   logic [3:0] r_fill;
   logic [3:0] w_fill_next;
   logic [7:0] r_count;
   logic [7:0] w_count_next;

   // Configuration latched at the accepted start.
   logic [7:0] r_pattern;
   logic [7:0] w_pattern_next;
   logic [3:0] r_len;
   logic [3:0] w_len_next;
   logic       r_overlap;
   logic       w_overlap_next;
   logic [7:0] r_target;
   logic [7:0] w_target_next;

   logic       r_match;
   logic       w_match_next;
   logic       r_err;
   logic       w_err_next;

   logic [7:0] w_word;
   logic [7:0] w_mask;
   logic [3:0] w_fill_inc;
   logic [7:0] w_count_inc;
   logic       w_cfg_legal;
   logic       w_hit;

   // Window mask: the low r_len bits take part in the compare.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_mask
         assign w_mask[gi] = (r_len > 4'(gi));
      end
   endgenerate

   assign w_word      = {r_hist, in};
   assign w_fill_inc  = (r_fill >= 4'd8) ? 4'd8 : (r_fill + 4'd1);
   assign w_count_inc = r_count + 8'd1;
   assign w_cfg_legal = (cfg_len >= 4'd1) && (cfg_len <= 4'd8) && (cfg_target != 8'd0);

   // The fill test makes sure every compared bit was received in this scan.
   // In non-overlap mode, it also makes sure the bits come after the previous
   // match.
   assign w_hit = (({1'b0, r_fill} + 5'd1) >= {1'b0, r_len}) &&
                  ((w_word & w_mask) == (r_pattern & w_mask));

   always_comb begin
      w_state_next   = r_state;
      w_hist_next    = r_hist;
      w_fill_next    = r_fill;
      w_count_next   = r_count;
      w_pattern_next = r_pattern;
      w_len_next     = r_len;
      w_overlap_next = r_overlap;
      w_target_next  = r_target;
      w_match_next   = 1'b0;
      w_err_next     = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_cfg_legal) begin
                  w_pattern_next = cfg_pattern;
                  w_len_next     = cfg_len;
                  w_overlap_next = cfg_overlap;
                  w_target_next  = cfg_target;
                  w_hist_next    = 7'd0;
                  w_fill_next    = 4'd0;
                  w_count_next   = 8'd0;
                  w_state_next   = SCAN;
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end

         SCAN: begin
            // abort wins over anything this cycle's sample would have done.
            if (abort) begin
               w_state_next = IDLE;
            end else if (in_valid) begin
               w_hist_next = w_word[6:0];
               w_fill_next = w_fill_inc;
               if (w_hit) begin
                  w_match_next = 1'b1;
                  w_count_next = w_count_inc;
                  if (!r_overlap) begin
                     w_fill_next = 4'd0;
                  end
                  if (w_count_inc == r_target) begin
                     w_state_next = DONE;
                  end
               end
            end
         end

         DONE: begin
            w_state_next = IDLE;
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_hist    <= 7'd0;
         r_fill    <= 4'd0;
         r_count   <= 8'd0;
         r_pattern <= 8'd0;
         r_len     <= 4'd0;
         r_overlap <= 1'b0;
         r_target  <= 8'd0;
         r_match   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_hist    <= w_hist_next;
         r_fill    <= w_fill_next;
         r_count   <= w_count_next;
         r_pattern <= w_pattern_next;
         r_len     <= w_len_next;
         r_overlap <= w_overlap_next;
         r_target  <= w_target_next;
         r_match   <= w_match_next;
         r_err     <= w_err_next;
      end
   end

   assign match       = r_match;
   assign err         = r_err;
   assign match_count = r_count;
   assign busy        = (r_state == SCAN);
   assign done        = (r_state == DONE);

endmodule
